// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, instruction opcodes, field positions and issue FSM states
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_NOT = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_SHL  = 4'h3;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
endpackage

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: register file, two combinational read ports, one synchronous write port
// ports: clk, reset (sync, active-high, clears all entries), ra1/ra2 -> rd1/rd2, we/wa/wd write
module reg_file_8x16 #(
    parameter int NREG = 8,
    parameter int W    = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd
);
    logic [W-1:0] mem [NREG];

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller driving an external 16-bit ALU
// ports: clk, reset (sync, active-high); instr_valid/instr_ready/instr handshake;
//        alu_a/alu_b/alu_control registered ALU drive, alu_result/alu_zero ALU response;
//        done pulse with done_rd/done_data/done_zero/done_err completion fields
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [15:0]  instr,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_control,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         done,
    output logic [2:0]   done_rd,
    output logic [W-1:0] done_data,
    output logic         done_zero,
    output logic         done_err
);
    state_t state, state_nx;
    logic [15:0] ir;
    logic [W-1:0] rd1, rd2;
    logic [3:0] opc;
    logic legal;

    assign opc   = ir[OPC_HI:OPC_LO];
    assign legal = opc <= OP_ADDI;

    reg_file_8x16 #(.NREG(NREG), .W(W)) u_rf (
        .clk  (clk),
        .reset(reset),
        .ra1  (ir[RS1_HI:RS1_LO]),
        .ra2  (ir[RS2_HI:RS2_LO]),
        .rd1  (rd1),
        .rd2  (rd2),
        .we   (done && !done_err),
        .wa   (done_rd),
        .wd   (done_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = instr_valid ? DECODE : IDLE;
            DECODE:  state_nx = legal ? EXEC : WB;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = state == IDLE;
        done        = state == WB;
    end

    // done_* load on the edge into WB, so they double as the result registers
    // and stay put until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir          <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            done_rd     <= '0;
            done_data   <= '0;
            done_zero   <= 1'b0;
            done_err    <= 1'b0;
        end else begin
            if (state == IDLE && instr_valid) ir <= instr;
            if (state == DECODE && legal) begin
                alu_control <= opc == OP_ADDI ? ALU_ADD : opc[2:0];
                alu_a       <= rd1;
                alu_b       <= opc == OP_ADDI ? {{(W-6){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]} : rd2;
            end
            if (state == DECODE && !legal) begin
                done_rd   <= ir[RD_HI:RD_LO];
                done_data <= '0;
                done_zero <= 1'b0;
                done_err  <= 1'b1;
            end
            if (state == EXEC) begin
                done_rd   <= ir[RD_HI:RD_LO];
                done_data <= alu_result;
                done_zero <= alu_zero;
                done_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed-vector bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        done, done_zero, done_err;
    logic [2:0]  done_rd;
    logic [15:0] done_data;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .done(done), .done_rd(done_rd),
        .done_data(done_data), .done_zero(done_zero), .done_err(done_err)
    );

    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = alu_a << alu_b[3:0];
            3'd4: alu_result = alu_a >> alu_b[3:0];
            3'd5: alu_result = alu_a & alu_b;
            3'd6: alu_result = alu_a | alu_b;
            default: alu_result = {15'b0, alu_a < alu_b};
        endcase
        alu_zero = alu_result == 16'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] ins, output int lat, output logic [15:0] a_ex, output logic [15:0] b_ex);
        int n = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 0;
        a_ex = '0;
        b_ex = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                a_ex = alu_a;
                b_ex = alu_b;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic op(input string tag, input logic [15:0] ins, input logic [15:0] exp_data,
                      input logic exp_zero, input logic exp_err, input int exp_lat);
        int lat;
        logic [15:0] a_ex, b_ex;
        issue(ins, lat, a_ex, b_ex);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".data"}, done_data, exp_data);
        check({tag, ".zero"}, done_zero, exp_zero);
        check({tag, ".err"}, done_err, exp_err);
        check({tag, ".rd"}, done_rd, ins[11:9]);
    endtask

    initial begin
        int lat, readies, dones;
        logic [15:0] a_ex, b_ex;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.ready", instr_ready, 1);
        check("rst.alu_a", alu_a, 0);
        check("rst.alu_b", alu_b, 0);
        check("rst.ctl", alu_control, 0);
        check("rst.done", done, 0);
        check("rst.data", done_data, 0);
        check("rst.err", done_err, 0);

        op("addi_r1", 16'h8205, 16'h0005, 1'b0, 1'b0, 3);
        op("addi_r2", 16'h843D, 16'hFFFD, 1'b0, 1'b0, 3);

        issue(16'h0650, lat, a_ex, b_ex);
        check("add.lat", lat, 3);
        check("add.alu_a", a_ex, 16'h0005);
        check("add.alu_b", b_ex, 16'hFFFD);
        check("add.data", done_data, 16'h0002);
        check("add.zero", done_zero, 0);

        op("sub_r4", 16'h18D8, 16'h0000, 1'b1, 1'b0, 3);
        op("slt_21", 16'h7A88, 16'h0000, 1'b1, 1'b0, 3);
        op("slt_12", 16'h7A50, 16'h0001, 1'b0, 1'b0, 3);
        op("illegal", 16'hBA50, 16'h0000, 1'b0, 1'b1, 2);
        op("rdback_r5", 16'h8D40, 16'h0001, 1'b0, 1'b0, 3);

        @(negedge clk);
        instr = 16'h8001;
        instr_valid = 1'b1;
        readies = 0;
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            if (instr_ready) readies++;
            if (done) dones++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("tput.ready", readies, 4);
        check("tput.done", dones, 4);
        op("rdback_r0", 16'h8E00, 16'h0004, 1'b0, 1'b0, 3);

        @(negedge clk);
        instr = 16'h0C48;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.alu_a", alu_a, 0);
        check("midrst.ready", instr_ready, 1);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("midrst.done", dones, 0);
        op("add_r7", 16'h0FB0, 16'h0000, 1'b1, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
